// File: rtl/pipe_spawn_scheduler_if.sv
// pipe_spawn_scheduler_if: key/die/slot-done inputs and spawn/status outputs of the spawn scheduler
// master: top-level game logic and pipe instances; slave: pipe_spawn_scheduler
interface pipe_spawn_scheduler_if #(
  parameter int NUM_SLOTS = 10
);
  logic                 game_start;
  logic                 die;
  logic [NUM_SLOTS-1:0] slot_done;
  logic [NUM_SLOTS-1:0] spawn;
  logic [8:0]           gap_y;
  logic [NUM_SLOTS-1:0] busy;
  logic [1:0]           state;
  logic                 clear_pipes;
  logic [7:0]           overflow_cnt;
  modport master (
    output game_start, die, slot_done,
    input  spawn, gap_y, busy, state, clear_pipes, overflow_cnt
  );
  modport slave (
    input  game_start, die, slot_done,
    output spawn, gap_y, busy, state, clear_pipes, overflow_cnt
  );
endinterface

// File: rtl/pipe_spawn_scheduler.sv
// pipe_spawn_scheduler: game FSM, spawn timer and round-robin pipe slot allocator
// Ports: clk; reset_n async active-low; bus (slave) takes game_start, die, slot_done and
// drives spawn (one-hot pulse), gap_y, busy, state, clear_pipes, overflow_cnt.
module pipe_spawn_scheduler #(
  parameter int          NUM_SLOTS    = 10,
  parameter int          SPAWN_PERIOD = 50000000,
  parameter int          GAP_MIN      = 80,
  parameter int          GAP_BITS     = 7,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic                   clk,
  input logic                   reset_n,
  pipe_spawn_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;
  localparam int PW = $clog2(NUM_SLOTS);
  localparam int IW = PW + 1;
  localparam int TW = $clog2(SPAWN_PERIOD);
  logic [15:0]          lfsr;
  logic [TW-1:0]        timer;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        ptr_nxt;
  logic [IW-1:0]        idx;
  logic [NUM_SLOTS-1:0] elig;
  logic [NUM_SLOTS-1:0] grant;
  logic                 found;
  logic                 tick;
  assign tick = (bus.state == PLAY) && (timer == TW'(SPAWN_PERIOD - 1));
  // a slot finishing in the tick cycle is already reusable by that tick
  assign elig = ~bus.busy | bus.slot_done;
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = {1'b0, ptr} + IW'(i);
      idx = (idx >= IW'(NUM_SLOTS)) ? idx - IW'(NUM_SLOTS) : idx;
      if (!found && elig[idx[PW-1:0]]) begin
        found = 1'b1;
        sel = idx[PW-1:0];
      end
    end
  end
  assign ptr_nxt = (sel == PW'(NUM_SLOTS - 1)) ? '0 : sel + PW'(1);
  assign grant = NUM_SLOTS'(1) << sel;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
      timer <= '0;
      ptr <= '0;
      bus.state <= IDLE;
      bus.spawn <= '0;
      bus.gap_y <= 9'(GAP_MIN);
      bus.busy <= '0;
      bus.clear_pipes <= 1'b0;
      bus.overflow_cnt <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      bus.spawn <= '0;
      bus.clear_pipes <= 1'b0;
      case (bus.state)
        IDLE, DEAD: begin
          if (bus.game_start) begin
            bus.state <= PLAY;
            timer <= '0;
            ptr <= '0;
            bus.overflow_cnt <= '0;
          end
        end
        PLAY: begin
          if (bus.die) begin
            bus.state <= DEAD;
            bus.clear_pipes <= 1'b1;
            bus.busy <= '0;
            timer <= '0;
          end else begin
            timer <= tick ? '0 : timer + TW'(1);
            bus.busy <= (bus.busy & ~bus.slot_done) | ((tick && found) ? grant : '0);
            if (tick && found) begin
              bus.spawn <= grant;
              bus.gap_y <= 9'(GAP_MIN) + 9'(lfsr[GAP_BITS-1:0]);
              ptr <= ptr_nxt;
            end
            if (tick && !found && bus.overflow_cnt != 8'hFF)
              bus.overflow_cnt <= bus.overflow_cnt + 8'd1;
          end
        end
        default: begin
          bus.state <= IDLE;
          bus.busy <= '0;
          timer <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_spawn_scheduler.sv
// tb_pipe_spawn_scheduler: directed scoreboard bench for pipe_spawn_scheduler (4 slots, period 8)
module tb_pipe_spawn_scheduler;
  localparam int N = 4;
  localparam int GAP_MIN = 80;
  localparam logic [15:0] SEED = 16'hACE1;
  typedef struct {
    logic [N-1:0] oh;
    int           due;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0, d, e;
  logic [15:0] m_lfsr = SEED;
  logic [15:0] m_prev = SEED;
  logic [8:0] last_gap = 9'(GAP_MIN);
  exp_t sbq[$];
  pipe_spawn_scheduler_if #(.NUM_SLOTS(N)) bus ();
  pipe_spawn_scheduler #(
    .NUM_SLOTS(N), .SPAWN_PERIOD(8), .GAP_MIN(GAP_MIN), .GAP_BITS(7), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic push(input logic [N-1:0] oh, input int due);
    exp_t x;
    x.oh = oh;
    x.due = due;
    sbq.push_back(x);
  endtask
  task automatic step();
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    m_prev = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    if (bus.spawn != '0 || (sbq.size() > 0 && sbq[0].due <= cyc)) begin
      if (sbq.size() == 0) chk("unexpected_spawn", 32'(bus.spawn), 32'd0);
      else begin
        x = sbq.pop_front();
        chk("spawn_slot", 32'(bus.spawn), 32'(x.oh));
        chk("spawn_cycle", 32'(cyc), 32'(x.due));
        if (bus.spawn != '0) begin
          chk("gap_y", 32'(bus.gap_y), 32'(GAP_MIN) + 32'(m_prev[6:0]));
          last_gap = bus.gap_y;
        end
      end
    end
  endtask
  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
    chk({tag, "_spawn"}, 32'(bus.spawn), 32'd0);
    chk({tag, "_gap_y"}, 32'(bus.gap_y), 32'(GAP_MIN));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_clear"}, 32'(bus.clear_pipes), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.overflow_cnt), 32'd0);
  endtask
  initial begin
    bus.game_start = 1'b0;
    bus.die = 1'b0;
    bus.slot_done = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset_n = 1'b1;
    m_lfsr = SEED;
    step();
    step();
    c0 = cyc;
    bus.game_start = 1'b1;
    push(4'b0001, c0 + 9);
    push(4'b0010, c0 + 17);
    push(4'b0100, c0 + 25);
    push(4'b1000, c0 + 33);
    step();
    bus.game_start = 1'b0;
    chk("state_play", 32'(bus.state), 32'd1);
    run_to(c0 + 12);
    bus.game_start = 1'b1;
    step();
    bus.game_start = 1'b0;
    run_to(c0 + 33);
    chk("busy_full", 32'(bus.busy), 32'hF);
    run_to(c0 + 41);
    chk("ovf_1", 32'(bus.overflow_cnt), 32'd1);
    chk("gap_held", 32'(bus.gap_y), 32'(last_gap));
    run_to(c0 + 49);
    chk("ovf_2", 32'(bus.overflow_cnt), 32'd2);
    run_to(c0 + 2449);
    chk("ovf_sat", 32'(bus.overflow_cnt), 32'd255);
    chk("busy_still_full", 32'(bus.busy), 32'hF);
    bus.slot_done = 4'b0100;
    push(4'b0100, c0 + 2457);
    step();
    bus.slot_done = '0;
    chk("busy_after_done", 32'(bus.busy), 32'hB);
    run_to(c0 + 2458);
    bus.slot_done = 4'b1001;
    push(4'b1000, c0 + 2465);
    push(4'b0001, c0 + 2473);
    step();
    bus.slot_done = '0;
    run_to(c0 + 2474);
    chk("busy_refill", 32'(bus.busy), 32'hF);
    bus.slot_done = 4'b1101;
    step();
    bus.slot_done = '0;
    chk("busy_only1", 32'(bus.busy), 32'h2);
    run_to(c0 + 2480);
    bus.slot_done = 4'b0010;
    push(4'b0010, c0 + 2481);
    push(4'b0100, c0 + 2489);
    push(4'b1000, c0 + 2497);
    push(4'b0001, c0 + 2505);
    step();
    bus.slot_done = '0;
    chk("busy_set_wins", 32'(bus.busy), 32'h2);
    run_to(c0 + 2506);
    bus.slot_done = 4'b1000;
    step();
    bus.slot_done = '0;
    chk("busy_0111", 32'(bus.busy), 32'h7);
    run_to(c0 + 2512);
    bus.die = 1'b1;
    bus.game_start = 1'b1;
    step();
    bus.game_start = 1'b0;
    chk("dead_state", 32'(bus.state), 32'd2);
    chk("dead_clear", 32'(bus.clear_pipes), 32'd1);
    chk("dead_busy", 32'(bus.busy), 32'd0);
    step();
    chk("clear_once", 32'(bus.clear_pipes), 32'd0);
    run_to(c0 + 2520);
    chk("dead_hold", 32'(bus.state), 32'd2);
    bus.die = 1'b0;
    d = cyc;
    bus.game_start = 1'b1;
    push(4'b0001, d + 9);
    step();
    bus.game_start = 1'b0;
    chk("restart_state", 32'(bus.state), 32'd1);
    chk("restart_ovf", 32'(bus.overflow_cnt), 32'd0);
    run_to(d + 9);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    chk("queue_after_restart", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_lfsr = SEED;
    e = cyc;
    bus.game_start = 1'b1;
    push(4'b0001, e + 9);
    step();
    bus.game_start = 1'b0;
    run_to(e + 10);
    chk("busy_after_rst", 32'(bus.busy), 32'h1);
    chk("queue_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
